psram_line_fetcher: RTL and testbench

- Initiator side of the PSRAM controller user interface (cmd/cmd_en/addr/wr_data/data_mask out; rd_data/rd_data_valid/init_calib in).
- Prefetches one video line as a sequence of 4-beat read bursts into a 64-bit FIFO.
- Serialises the FIFO contents to a byte stream for the composite video pixel pipeline.
- Interleaves single-byte CPU/host writes between bursts.

---
 rtl/psram_line_fetcher_pkg.sv | 22 ++
 rtl/psram_line_fetcher_if.sv | 37 +++
 rtl/sync_fifo64.sv | 52 +++++
 rtl/psram_line_fetcher.sv | 236 +++++++++++++++++++++++
 tb/tb_psram_line_fetcher.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_line_fetcher_pkg.sv
// Shared types and constants for the PSRAM line fetcher.
// Holds the fetch FSM state enum, command encodings and default timing.
package psram_client_pkg;

    typedef enum logic [2:0] {
        WAIT_CALIB,
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_CMD,
        GAP
    } fetch_state_t;

    localparam logic       CMD_READ   = 1'b0;
    localparam logic       CMD_WRITE  = 1'b1;
    localparam logic [7:0] BYTE0_MASK = 8'hFE;

    localparam int DEF_BURST_BEATS = 4;
    localparam int DEF_CMD_GAP     = 15;
    localparam int ADDR_W          = 21;

endpackage

// File: rtl/psram_line_fetcher_if.sv
// PSRAM controller user-side bus.
// master: the fetcher (issues cmd/addr/data, receives rd beats); slave: controller.
interface psram_line_fetcher_if;
    import psram_client_pkg::*;

    logic              init_calib;
    logic              cmd;
    logic              cmd_en;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wr_data;
    logic [7:0]        data_mask;
    logic [63:0]       rd_data;
    logic              rd_data_valid;

    modport master (
        input  init_calib,
        input  rd_data,
        input  rd_data_valid,
        output cmd,
        output cmd_en,
        output addr,
        output wr_data,
        output data_mask
    );

    modport slave (
        output init_calib,
        output rd_data,
        output rd_data_valid,
        input  cmd,
        input  cmd_en,
        input  addr,
        input  wr_data,
        input  data_mask
    );

endinterface

// File: rtl/sync_fifo64.sv
// Single-clock 64-bit show-ahead FIFO with occupancy and synchronous flush.
// Ports: clk, reset, flush, push/din, pop/dout, empty, full, level.
module sync_fifo64 #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [63:0]            din,
    input  logic                   pop,
    output logic [63:0]            dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0] ram [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign dout    = ram[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            ram[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/psram_line_fetcher.sv
// Prefetches a video line from PSRAM in read bursts, serialises it to bytes,
// and slots single-byte host writes between bursts.
// Ports: clk, reset, mem (PSRAM user bus, master), line_start/line_addr/
// line_bursts, busy, pix_data/pix_valid/pix_ready, wr_req/wr_addr/wr_byte/
// wr_ack, rd_error.
module psram_line_fetcher
    import psram_client_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int BURST_BEATS = DEF_BURST_BEATS,
    parameter int ADDR_STEP   = 16,
    parameter int CMD_GAP     = DEF_CMD_GAP,
    parameter int RD_TIMEOUT  = 63
) (
    input  logic                 clk,
    input  logic                 reset,
    psram_line_fetcher_if.master mem,
    input  logic                 line_start,
    input  logic [ADDR_W-1:0]    line_addr,
    input  logic [7:0]           line_bursts,
    output logic                 busy,
    output logic [7:0]           pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    input  logic                 wr_req,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [7:0]           wr_byte,
    output logic                 wr_ack,
    output logic                 rd_error
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_BEATS + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam int GW = $clog2(CMD_GAP + 1);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        bursts_left;
    logic [BW-1:0]     beat_cnt;
    logic [TW-1:0]     to_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              discard;

    logic              f_push;
    logic              f_pop;
    logic [63:0]       f_dout;
    logic              f_empty;
    logic              f_full;
    logic [LW-1:0]     f_level;
    logic [LW-1:0]     f_free;

    logic              rd_ok;
    logic              wr_win;
    logic              beat_last;
    logic              timeout;
    logic              gap_near;
    logic              beat_keep;
    logic              overflow;

    logic [63:0]       sh;
    logic [2:0]        byte_idx;
    logic              take;

    sync_fifo64 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (line_start),
        .push  (f_push),
        .din   (mem.rd_data),
        .pop   (f_pop),
        .dout  (f_dout),
        .empty (f_empty),
        .full  (f_full),
        .level (f_level)
    );

    assign f_free   = LW'(FIFO_DEPTH) - f_level;
    assign rd_ok    = (bursts_left != 8'd0) && (f_free >= LW'(BURST_BEATS));
    // With data already buffered the pixel stream can ride out a write.
    assign wr_win   = wr_req && (!rd_ok || (f_level >= LW'(2)));
    assign beat_last = mem.rd_data_valid && (beat_cnt == BW'(BURST_BEATS - 1));
    assign timeout  = (beat_cnt == '0) && !mem.rd_data_valid
                      && (to_cnt == TW'(RD_TIMEOUT - 1));
    // gap_cnt reaches zero next cycle: IDLE may issue then.
    assign gap_near = (gap_cnt <= GW'(1));

    // Beats of a burst abandoned by line_start are counted but never stored.
    assign beat_keep = (state == RD_WAIT) && mem.rd_data_valid
                       && !discard && !line_start;
    assign f_push    = beat_keep && !f_full;
    assign overflow  = beat_keep && f_full;

    assign busy = (bursts_left != 8'd0)
                  || !((state == IDLE) || (state == WAIT_CALIB));

    always_comb begin
        state_n = state;
        unique case (state)
            WAIT_CALIB: begin
                if (mem.init_calib) state_n = IDLE;
            end
            IDLE: begin
                if (!mem.init_calib) begin
                    state_n = WAIT_CALIB;
                end else if (!line_start && (gap_cnt == '0)) begin
                    if (wr_win)     state_n = WR_CMD;
                    else if (rd_ok) state_n = RD_CMD;
                end
            end
            RD_CMD: begin
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (timeout)        state_n = GAP;
                else if (beat_last) state_n = gap_near ? IDLE : GAP;
            end
            WR_CMD: begin
                state_n = GAP;
            end
            GAP: begin
                if (gap_near) state_n = IDLE;
            end
            default: begin
                state_n = WAIT_CALIB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= WAIT_CALIB;
            cur_addr      <= '0;
            bursts_left   <= '0;
            beat_cnt      <= '0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            discard       <= 1'b0;
            rd_error      <= 1'b0;
            wr_ack        <= 1'b0;
            mem.cmd_en    <= 1'b0;
            mem.cmd       <= CMD_READ;
            mem.addr      <= '0;
            mem.wr_data   <= '0;
            mem.data_mask <= 8'hFF;
        end else begin
            state      <= state_n;
            mem.cmd_en <= 1'b0;
            wr_ack     <= 1'b0;

            // Command outputs are registered so they line up with the
            // RD_CMD / WR_CMD state cycle.
            if ((state == IDLE) && (state_n == RD_CMD)) begin
                mem.cmd_en    <= 1'b1;
                mem.cmd       <= CMD_READ;
                mem.addr      <= cur_addr;
                mem.data_mask <= 8'hFF;
            end
            if ((state == IDLE) && (state_n == WR_CMD)) begin
                mem.cmd_en    <= 1'b1;
                mem.cmd       <= CMD_WRITE;
                mem.addr      <= wr_addr;
                mem.wr_data   <= {56'h0, wr_byte};
                mem.data_mask <= BYTE0_MASK;
                wr_ack        <= 1'b1;
            end

            if ((state == RD_CMD) || (state == WR_CMD)) begin
                gap_cnt <= GW'(CMD_GAP - 2);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (line_start) begin
                cur_addr    <= line_addr;
                bursts_left <= line_bursts;
            end else if (state == RD_CMD) begin
                cur_addr    <= cur_addr + ADDR_W'(ADDR_STEP);
                bursts_left <= bursts_left - 8'd1;
            end

            if (line_start && ((state == RD_CMD) || (state == RD_WAIT))) begin
                discard <= 1'b1;
            end else if (state == RD_CMD) begin
                discard <= 1'b0;
            end

            if (state == RD_CMD) begin
                beat_cnt <= '0;
                to_cnt   <= '0;
            end else if (state == RD_WAIT) begin
                if (mem.rd_data_valid) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end else if (beat_cnt == '0) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            if (((state == RD_WAIT) && timeout) || overflow) begin
                rd_error <= 1'b1;
            end
        end
    end

    // Serializer: one FIFO entry at a time, MSB byte first.
    assign pix_data = sh[63:56];
    assign take     = pix_valid && pix_ready;
    assign f_pop    = !line_start && !f_empty
                      && (!pix_valid || (take && (byte_idx == 3'd7)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh        <= '0;
            byte_idx  <= '0;
            pix_valid <= 1'b0;
        end else if (line_start) begin
            byte_idx  <= '0;
            pix_valid <= 1'b0;
        end else if (f_pop) begin
            sh        <= f_dout;
            byte_idx  <= '0;
            pix_valid <= 1'b1;
        end else if (take) begin
            if (byte_idx == 3'd7) begin
                pix_valid <= 1'b0;
            end else begin
                sh       <= {sh[55:0], 8'h00};
                byte_idx <= byte_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_psram_line_fetcher.sv
// Self-checking bench for psram_line_fetcher: PSRAM responder model,
// pixel consumer with byte scoreboard, and directed scenario sequence.
module tb_psram_line_fetcher;
    import psram_client_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [20:0] line_addr;
    logic [7:0]  line_bursts;
    logic        busy;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        wr_req;
    logic [20:0] wr_addr;
    logic [7:0]  wr_byte;
    logic        wr_ack;
    logic        rd_error;

    always #5 clk = ~clk;

    psram_line_fetcher_if mem();

    psram_line_fetcher dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (mem),
        .line_start  (line_start),
        .line_addr   (line_addr),
        .line_bursts (line_bursts),
        .busy        (busy),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_byte     (wr_byte),
        .wr_ack      (wr_ack),
        .rd_error    (rd_error)
    );

    typedef struct {
        logic        cmd;
        logic [20:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic        ack;
        int          cyc;
    } cmd_rec_t;

    cmd_rec_t   log_q[$];
    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_pix    = 0;
    int         beats_sent = 0;
    int         beat_gap = 0;
    bit         ignore_next = 1'b0;
    bit         drop_rest = 1'b0;
    logic [7:0] data_ctr = 8'h00;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int n_reads();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].cmd == CMD_READ) n++;
        return n;
    endfunction

    function automatic logic [20:0] rec_addr(input int i);
        if (i < log_q.size()) return log_q[i].addr;
        return 21'h1FFFFF;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // PSRAM responder: logs every command, answers reads with 4 beats.
    initial begin
        cmd_rec_t   rec;
        logic [63:0] beat;
        mem.rd_data       = '0;
        mem.rd_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && mem.cmd_en) begin
                rec.cmd   = mem.cmd;
                rec.addr  = mem.addr;
                rec.wdata = mem.wr_data;
                rec.mask  = mem.data_mask;
                rec.ack   = wr_ack;
                rec.cyc   = cyc;
                log_q.push_back(rec);
                if (mem.cmd == CMD_READ) begin
                    drop_rest = 1'b0;
                    if (ignore_next) begin
                        ignore_next = 1'b0;
                    end else begin
                        @(posedge clk);
                        #1;
                        for (int b = 0; b < 4; b++) begin
                            for (int k = 0; k < 8; k++) begin
                                beat[63-8*k -: 8] = data_ctr + 8'(k);
                                if (!drop_rest) sb.push_back(data_ctr + 8'(k));
                            end
                            data_ctr          = data_ctr + 8'd8;
                            mem.rd_data       = beat;
                            mem.rd_data_valid = 1'b1;
                            beats_sent++;
                            @(posedge clk);
                            #1;
                            mem.rd_data_valid = 1'b0;
                            repeat (beat_gap) begin
                                @(posedge clk);
                                #1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Pixel consumer and scoreboard compare.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && pix_valid && pix_ready) begin
                n_pix++;
                if (sb.size() == 0) check("pix_extra", sb.size(), 1);
                else check("pix_data", pix_data, sb.pop_front());
            end
        end
    end

    task automatic start_line(input logic [20:0] a, input logic [7:0] n);
        @(posedge clk);
        #1;
        line_start  = 1'b1;
        line_addr   = a;
        line_bursts = n;
        @(posedge clk);
        #1;
        line_start  = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy || (sb.size() != 0) || pix_valid) && (n < max)) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", n < max, 1);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1;
        pix_ready = r;
    endtask

    initial begin
        int n;
        int t0;
        reset          = 1'b1;
        line_start     = 1'b0;
        line_addr      = '0;
        line_bursts    = '0;
        pix_ready      = 1'b0;
        wr_req         = 1'b0;
        wr_addr        = '0;
        wr_byte        = '0;
        mem.init_calib = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        check("rst_cmd_en", mem.cmd_en, 0);
        check("rst_cmd", mem.cmd, 0);
        check("rst_addr", mem.addr, 0);
        check("rst_wr_data", mem.wr_data, 0);
        check("rst_mask", mem.data_mask, 8'hFF);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_error", rd_error, 0);

        // Calibration gating, then byte order.
        set_ready(1'b1);
        start_line(21'h0, 8'd2);
        repeat (50) @(negedge clk);
        check("calib_no_cmd", log_q.size(), 0);
        check("calib_busy", busy, 1);
        @(posedge clk);
        #1;
        mem.init_calib = 1'b1;
        wait_idle(400);
        check("calib_rd_count", n_reads(), 2);
        check("calib_addr0", rec_addr(0), 21'h0);
        check("calib_addr1", rec_addr(1), 21'h10);
        if (log_q.size() >= 2)
            check("calib_gap", (log_q[1].cyc - log_q[0].cyc) >= 15, 1);
        check("order_bytes", n_pix, 64);
        check("order_busy_low", busy, 0);

        // Backpressure.
        log_q.delete();
        n_pix = 0;
        set_ready(1'b0);
        start_line(21'h1000, 8'd8);
        repeat (250) @(negedge clk);
        check("bp_rd_cmds", n_reads(), 4);
        check("bp_pix_valid", pix_valid, 1);
        if (sb.size() != 0) check("bp_pix_head", pix_data, sb[0]);
        set_ready(1'b1);
        wait_idle(2000);
        check("bp_rd_total", n_reads(), 8);
        for (int i = 0; i < 8; i++)
            check("bp_addr", rec_addr(i), 21'h1000 + 21'(16 * i));
        check("bp_bytes", n_pix, 256);
        check("bp_rd_error", rd_error, 0);

        // Write interleave.
        log_q.delete();
        n_pix = 0;
        beats_sent = 0;
        set_ready(1'b0);
        start_line(21'h2000, 8'd4);
        n = 0;
        while (!((n_reads() >= 1) && (beats_sent >= 4)) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("wr_setup", n < 100, 1);
        @(posedge clk);
        #1;
        wr_req  = 1'b1;
        wr_addr = 21'h123;
        wr_byte = 8'hA5;
        n = 0;
        while (!wr_ack && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("wr_ack_seen", wr_ack, 1);
        check("wr_ack_cmd_en", mem.cmd_en, 1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        @(negedge clk);
        check("wr_ack_pulse", wr_ack, 0);
        check("wr_log_size", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("wr_cmd", log_q[1].cmd, CMD_WRITE);
            check("wr_addr", log_q[1].addr, 21'h123);
            check("wr_data", log_q[1].wdata, 64'hA5);
            check("wr_mask", log_q[1].mask, 8'hFE);
            check("wr_ack_coinc", log_q[1].ack, 1);
        end
        set_ready(1'b1);
        wait_idle(2000);
        check("wr_rd_total", n_reads(), 4);
        check("wr_bytes", n_pix, 128);

        // Mid-burst restart.
        log_q.delete();
        n_pix = 0;
        beats_sent = 0;
        beat_gap = 2;
        set_ready(1'b0);
        start_line(21'h800, 8'd1);
        n = 0;
        while (!((n_reads() >= 1) && (beats_sent >= 2)) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("rs_setup", n < 100, 1);
        @(posedge clk);
        #1;
        drop_rest   = 1'b1;
        sb.delete();
        n_pix       = 0;
        line_start  = 1'b1;
        line_addr   = 21'h400;
        line_bursts = 8'd1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        @(negedge clk);
        check("rs_flush", pix_valid, 0);
        set_ready(1'b1);
        wait_idle(500);
        beat_gap = 0;
        check("rs_rd_total", n_reads(), 2);
        check("rs_addr_old", rec_addr(0), 21'h800);
        check("rs_addr_new", rec_addr(1), 21'h400);
        check("rs_bytes", n_pix, 32);

        // Read timeout.
        log_q.delete();
        n_pix = 0;
        ignore_next = 1'b1;
        start_line(21'h3000, 8'd2);
        n = 0;
        while ((n_reads() < 1) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("to_first_cmd", n < 100, 1);
        t0 = (log_q.size() != 0) ? log_q[0].cyc : cyc;
        while (cyc < t0 + 63) @(negedge clk);
        check("to_err_early", rd_error, 0);
        @(negedge clk);
        check("to_err_set", rd_error, 1);
        wait_idle(500);
        check("to_rd_total", n_reads(), 2);
        check("to_next_addr", rec_addr(1), 21'h3010);
        check("to_bytes", n_pix, 32);
        check("to_err_sticky", rd_error, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
